// File: rtl/half_adder_1bit.sv
// -----------------------------------------------------------------------------
// half_adder_1bit
//
// Registered 1-bit half adder with a saturating carry-event counter.
// A qualified sample (in_valid = 1) produces {output_carry, output_sum} = a + b
// one cycle later, flagged by a single-cycle out_valid pulse. Every accepted
// 1+1 operation increments carry_count, which stops at all-ones.
//
// Ports
//   Clk             in   rising-edge clock
//   Rst_n           in   synchronous active-low reset
//   input_a         in   operand A
//   input_b         in   operand B
//   in_valid        in   qualifies input_a / input_b this cycle
//   cnt_clear       in   synchronous clear of carry_count (wins over a carry)
//   output_carry    out  registered a AND b
//   output_sum      out  registered a XOR b
//   out_valid       out  one-cycle strobe for a new result
//   carry_count     out  saturating count of accepted carry events [CNT_W]
//   carry_count_sat out  high while carry_count is all-ones
// -----------------------------------------------------------------------------
module half_adder_1bit #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             input_a,
    input  logic             input_b,
    input  logic             in_valid,
    input  logic             cnt_clear,
    output logic             output_carry,
    output logic             output_sum,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count,
    output logic             carry_count_sat
);

    logic             carry_event;
    logic             cnt_at_max;
    logic [CNT_W-1:0] cnt_next;

    // in_valid gates the operands first so unknown operands on idle cycles
    // cannot reach the counter.
    always_comb begin
        carry_event = 1'b0;
        cnt_at_max  = (carry_count == '1);
        cnt_next    = carry_count;
        if (in_valid) begin
            carry_event = input_a & input_b;
        end
        if (cnt_clear) begin
            cnt_next = '0;
        end else if (carry_event && !cnt_at_max) begin
            cnt_next = carry_count + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            output_carry    <= 1'b0;
            output_sum      <= 1'b0;
            out_valid       <= 1'b0;
            carry_count     <= '0;
            carry_count_sat <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                output_carry <= input_a & input_b;
                output_sum   <= input_a ^ input_b;
            end
            carry_count     <= cnt_next;
            // Compare on the next value so the flag rises with the count.
            carry_count_sat <= (cnt_next == '1);
        end
    end

endmodule

// File: tb/tb_half_adder_1bit.sv
// -----------------------------------------------------------------------------
// tb_half_adder_1bit
//
// Directed bench for half_adder_1bit. Two instances share stimulus: dut8 uses
// the default counter width, dut2 uses CNT_W = 2 for the saturation scenario.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_half_adder_1bit;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       vld;
    logic       clr;

    logic       carry8, sum8, ov8, sat8;
    logic [7:0] cnt8;
    logic       carry2, sum2, ov2, sat2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    half_adder_1bit #(.CNT_W(8)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .input_a(a), .input_b(b),
        .in_valid(vld), .cnt_clear(clr),
        .output_carry(carry8), .output_sum(sum8), .out_valid(ov8),
        .carry_count(cnt8), .carry_count_sat(sat8)
    );

    half_adder_1bit #(.CNT_W(2)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .input_a(a), .input_b(b),
        .in_valid(vld), .cnt_clear(clr),
        .output_carry(carry2), .output_sum(sum2), .out_valid(ov2),
        .carry_count(cnt2), .carry_count_sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic ia,
                         input logic ib, input logic c);
        rst_n = r;
        vld   = v;
        a     = ia;
        b     = ib;
        clr   = c;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if ({carry8, sum8, ov8, cnt8, sat8} !== 12'h000) begin
            errors++;
            $display("FAIL reset_dut8: got c=%b s=%b v=%b cnt=%0d sat=%b, want all 0",
                     carry8, sum8, ov8, cnt8, sat8);
        end
        checks++;
        if ({carry2, sum2, ov2, cnt2, sat2} !== 6'h00) begin
            errors++;
            $display("FAIL reset_dut2: got c=%b s=%b v=%b cnt=%0d sat=%b, want all 0",
                     carry2, sum2, ov2, cnt2, sat2);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] va [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
        logic [1:0] ve [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, va[i][1], va[i][0], 1'b0);
            step();
            checks++;
            if ({carry8, sum8, ov8} !== {ve[i], 1'b1}) begin
                errors++;
                $display("FAIL truth_%0d: got c/s/v=%b%b%b, want %b%b1",
                         i, carry8, sum8, ov8, ve[i][1], ve[i][0]);
            end
        end
        checks++;
        if (cnt8 !== 8'd1) begin
            errors++;
            $display("FAIL truth_count: got %0d, want 1", cnt8);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if ({carry8, sum8, ov8, cnt8} !== {3'b101, 8'd2}) begin
            errors++;
            $display("FAIL hold_load: got c=%b s=%b v=%b cnt=%0d, want 1 0 1 2",
                     carry8, sum8, ov8, cnt8);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({carry8, sum8, ov8, cnt8} !== {3'b100, 8'd2}) begin
                errors++;
                $display("FAIL hold_%0d: got c=%b s=%b v=%b cnt=%0d, want 1 0 0 2",
                         i, carry8, sum8, ov8, cnt8);
            end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       es [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({cnt2, sat2} !== {ec[i], es[i]}) begin
                errors++;
                $display("FAIL sat_%0d: got cnt=%0d sat=%b, want cnt=%0d sat=%b",
                         i, cnt2, sat2, ec[i], es[i]);
            end
        end
        checks++;
        if ({cnt8, sat8} !== {8'd5, 1'b0}) begin
            errors++;
            $display("FAIL sat_wide: got cnt=%0d sat=%b, want 5 0", cnt8, sat8);
        end
    endtask

    task automatic test_clear();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if ({cnt8, sat8, cnt2, sat2} !== 12'h000) begin
            errors++;
            $display("FAIL clear_count: got cnt8=%0d sat8=%b cnt2=%0d sat2=%b, want 0",
                     cnt8, sat8, cnt2, sat2);
        end
        checks++;
        if ({carry8, sum8, ov8} !== 3'b101) begin
            errors++;
            $display("FAIL clear_result: got c/s/v=%b%b%b, want 101", carry8, sum8, ov8);
        end
        clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        step();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        checks++;
        if ({carry8, sum8, ov8, cnt8, sat8, carry2, sum2, ov2, cnt2, sat2} !== 18'h0) begin
            errors++;
            $display("FAIL midrst_zero: got c=%b s=%b v=%b cnt=%0d sat=%b cnt2=%0d sat2=%b, want 0",
                     carry8, sum8, ov8, cnt8, sat8, cnt2, sat2);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if ({carry8, sum8, ov8, cnt8} !== {3'b011, 8'd0}) begin
            errors++;
            $display("FAIL midrst_next: got c=%b s=%b v=%b cnt=%0d, want 0 1 1 0",
                     carry8, sum8, ov8, cnt8);
        end
    endtask

    task automatic test_x_inputs();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'bx, 1'bx, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({carry8, sum8, ov8, cnt8, sat8} !== {3'b010, 8'd0, 1'b0} ||
                $isunknown({carry2, sum2, ov2, cnt2, sat2})) begin
                errors++;
                $display("FAIL xin_%0d: got c=%b s=%b v=%b cnt=%0d sat=%b, want 0 1 0 0 0",
                         i, carry8, sum8, ov8, cnt8, sat8);
            end
        end
        vld = 1'b0;
        a   = 1'b0;
        b   = 1'b0;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_truth_table();
        test_hold();
        test_saturate();
        test_clear();
        test_reset_mid();
        test_x_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
